// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives a single-outstanding imem
// request/response port, and holds the IF/ID pipeline register plus a one-entry hold buffer.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        keep_PC,
  input  logic        keep_IF_ID,
  input  logic        flush_IF_ID,
  input  logic        npc_op,
  input  logic [31:0] npc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_ID,
  output logic [31:0] pc4_ID,
  output logic [31:0] inst_ID,
  output logic        valid_ID,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a cycle where imem_req & imem_ready are both
  // high; imem_addr is held stable while imem_req waits for imem_ready. Responses
  // (imem_rvalid) are always accepted and matched to the single outstanding request.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_f;
  logic [31:0] req_pc;
  logic        hold_valid, hold_valid_d;
  logic [31:0] hold_inst;
  logic [31:0] hold_pc;

  logic accept;
  logic arrive;
  logic hold_use;
  logic hold_capture;
  logic unused_target_bits;

  assign unused_target_bits = ^npc_target[1:0];

  assign imem_req = ((state_q == S_REQ) |
                     ((state_q == S_WAIT) & imem_rvalid & ~keep_IF_ID)) &
                    ~hold_valid & ~keep_PC & ~npc_op;
  assign imem_addr = pc_f;
  assign accept    = imem_req & imem_ready;
  assign dbg_state = state_q;

  // A redirect kills both the word in flight and anything parked in hold.
  assign arrive       = (state_q == S_WAIT) & imem_rvalid & ~npc_op;
  assign hold_use     = hold_valid & ~npc_op;
  assign hold_capture = ~flush_IF_ID & keep_IF_ID & arrive;

  always_comb begin
    state_d = state_q;
    if (npc_op) begin
      case (state_q)
        S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
        default: state_d = state_q;
      endcase
    end else if (accept) begin
      state_d = S_WAIT;
    end else if ((state_q == S_WAIT || state_q == S_DROP) && imem_rvalid) begin
      state_d = S_REQ;
    end
  end

  always_comb begin
    hold_valid_d = hold_valid;
    if (npc_op) begin
      hold_valid_d = 1'b0;
    end else if (flush_IF_ID) begin
      hold_valid_d = hold_valid;
    end else if (keep_IF_ID) begin
      if (arrive) hold_valid_d = 1'b1;
    end else begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_f       <= RESET_PC;
      req_pc     <= RESET_PC;
      hold_valid <= 1'b0;
      hold_inst  <= NOP;
      hold_pc    <= 32'h0;
      valid_ID   <= 1'b0;
      inst_ID    <= NOP;
      pc_ID      <= 32'h0;
      pc4_ID     <= 32'h4;
    end else begin
      state_q    <= state_d;
      hold_valid <= hold_valid_d;

      if (npc_op) begin
        pc_f <= {npc_target[31:2], 2'b00};
      end else if (accept) begin
        pc_f <= pc_f + 32'd4;
      end
      if (accept) req_pc <= pc_f;

      if (hold_capture) begin
        hold_inst <= imem_rdata;
        hold_pc   <= req_pc;
      end

      if (flush_IF_ID) begin
        valid_ID <= 1'b0;
        inst_ID  <= NOP;
      end else if (keep_IF_ID) begin
        valid_ID <= valid_ID;
      end else if (hold_use) begin
        valid_ID <= 1'b1;
        inst_ID  <= hold_inst;
        pc_ID    <= hold_pc;
        pc4_ID   <= hold_pc + 32'd4;
      end else if (arrive) begin
        valid_ID <= 1'b1;
        inst_ID  <= imem_rdata;
        pc_ID    <= req_pc;
        pc4_ID   <= req_pc + 32'd4;
      end else begin
        valid_ID <= 1'b0;
        inst_ID  <= NOP;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, streaming, stall/hold, redirects, PC wrap
// and mid-operation reset, stepped cycle by cycle with hand-computed expectations.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] XMASK    = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        keep_PC;
  logic        keep_IF_ID;
  logic        flush_IF_ID;
  logic        npc_op;
  logic [31:0] npc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_ID;
  logic [31:0] pc4_ID;
  logic [31:0] inst_ID;
  logic        valid_ID;
  logic [1:0]  dbg_state;

  int tests;
  int fails;

  if_fetch #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .keep_PC(keep_PC), .keep_IF_ID(keep_IF_ID), .flush_IF_ID(flush_IF_ID),
    .npc_op(npc_op), .npc_target(npc_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_ID(pc_ID), .pc4_ID(pc4_ID), .inst_ID(inst_ID), .valid_ID(valid_ID),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] inst);
    chk({tag, ".valid"}, {31'd0, valid_ID}, {31'd0, v});
    chk({tag, ".inst"}, inst_ID, inst);
    if (v) begin
      chk({tag, ".pc"}, pc_ID, pc);
      chk({tag, ".pc4"}, pc4_ID, pc + 32'd4);
    end
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic resp(input logic v, input logic [31:0] a);
    imem_rvalid = v;
    imem_rdata  = v ? (a ^ XMASK) : 32'hDEAD_BEEF;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0; keep_PC = 1'b0; keep_IF_ID = 1'b0; flush_IF_ID = 1'b0;
    npc_op = 1'b0; npc_target = 32'h0;
    imem_ready = 1'b1; resp(1'b0, 32'h0);

    // reset
    tick(); tick();
    chk("rst.valid", {31'd0, valid_ID}, 32'd0);
    chk("rst.inst", inst_ID, NOP);
    chk("rst.pc", pc_ID, 32'h0);
    chk("rst.pc4", pc4_ID, 32'h4);
    chk("rst.state", {30'd0, dbg_state}, 32'd0);

    // C0: first request after release
    rst_n = 1'b1;
    settle(); chk_req("c0", 1'b1, 32'h100);
    tick();

    // streaming, zero-wait
    resp(1'b1, 32'h100);
    settle(); chk_req("c1", 1'b1, 32'h104);
    tick(); chk_id("s100", 1'b1, 32'h100, 32'h100 ^ XMASK);
    resp(1'b1, 32'h104);
    settle(); chk_req("c2", 1'b1, 32'h108);
    tick(); chk_id("s104", 1'b1, 32'h104, 32'h104 ^ XMASK);

    // stall while 0x108 arrives: goes to hold
    keep_PC = 1'b1; keep_IF_ID = 1'b1; resp(1'b1, 32'h108);
    settle(); chk_req("stall0", 1'b0, 32'h0);
    tick(); chk_id("stall0", 1'b1, 32'h104, 32'h104 ^ XMASK);
    resp(1'b0, 32'h0);
    settle(); chk_req("stall1", 1'b0, 32'h0);
    tick(); chk_id("stall1", 1'b1, 32'h104, 32'h104 ^ XMASK);
    settle(); chk_req("stall2", 1'b0, 32'h0);
    tick(); chk_id("stall2", 1'b1, 32'h104, 32'h104 ^ XMASK);

    // release: hold forwarded, no request while hold is full
    keep_PC = 1'b0; keep_IF_ID = 1'b0;
    settle(); chk_req("release", 1'b0, 32'h0);
    tick(); chk_id("held108", 1'b1, 32'h108, 32'h108 ^ XMASK);
    settle(); chk_req("resume", 1'b1, 32'h10C);
    tick(); chk_id("bubble10c", 1'b0, 32'h0, NOP);

    // latency-3 redirect: 0x10C returns, 0x110 accepted then dropped
    resp(1'b1, 32'h10C);
    settle(); chk_req("c8", 1'b1, 32'h110);
    tick(); chk_id("s10c", 1'b1, 32'h10C, 32'h10C ^ XMASK);
    resp(1'b0, 32'h0); npc_op = 1'b1; flush_IF_ID = 1'b1; npc_target = 32'h203;
    settle(); chk_req("redir", 1'b0, 32'h0);
    tick(); chk_id("redir", 1'b0, 32'h0, NOP);
    chk("redir.state", {30'd0, dbg_state}, 32'd2);
    chk("redir.pcid", pc_ID, 32'h10C);
    npc_op = 1'b0; flush_IF_ID = 1'b0;
    settle(); chk_req("drop0", 1'b0, 32'h0);
    tick();
    resp(1'b1, 32'h110);
    settle(); chk_req("drop1", 1'b0, 32'h0);
    tick(); chk_id("stale110", 1'b0, 32'h0, NOP);
    resp(1'b0, 32'h0); imem_ready = 1'b0;
    settle(); chk_req("tgt_nr", 1'b1, 32'h200);
    tick();
    imem_ready = 1'b1;
    settle(); chk_req("tgt_stable", 1'b1, 32'h200);
    tick();

    // redirect coincident with rvalid
    resp(1'b1, 32'h200); npc_op = 1'b1; flush_IF_ID = 1'b1; npc_target = 32'h300;
    settle(); chk_req("coinc", 1'b0, 32'h0);
    tick(); chk_id("coinc", 1'b0, 32'h0, NOP);
    chk("coinc.state", {30'd0, dbg_state}, 32'd0);
    resp(1'b0, 32'h0); npc_op = 1'b0; flush_IF_ID = 1'b0;
    settle(); chk_req("t300", 1'b1, 32'h300);
    tick();

    // redirect while hold is full
    resp(1'b1, 32'h300); keep_PC = 1'b1; keep_IF_ID = 1'b1;
    tick(); chk_id("hold300", 1'b0, 32'h0, NOP);
    resp(1'b0, 32'h0); npc_op = 1'b1; flush_IF_ID = 1'b1; npc_target = 32'hFFFF_FFFC;
    settle(); chk_req("hredir", 1'b0, 32'h0);
    tick(); chk_id("hredir", 1'b0, 32'h0, NOP);
    keep_PC = 1'b0; keep_IF_ID = 1'b0; npc_op = 1'b0; flush_IF_ID = 1'b0;
    settle(); chk_req("tfffc", 1'b1, 32'hFFFF_FFFC);
    tick(); chk_id("nohold", 1'b0, 32'h0, NOP);

    // wrap
    resp(1'b1, 32'hFFFF_FFFC);
    settle(); chk_req("wrap", 1'b1, 32'h0);
    tick(); chk_id("sfffc", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC ^ XMASK);

    // mid-op reset while WAIT for 0x0
    resp(1'b0, 32'h0); rst_n = 1'b0;
    tick();
    chk("mrst.state", {30'd0, dbg_state}, 32'd0);
    chk_id("mrst", 1'b0, 32'h0, NOP);
    chk("mrst.pc", pc_ID, 32'h0);
    chk("mrst.pc4", pc4_ID, 32'h4);
    rst_n = 1'b1; imem_ready = 1'b0; resp(1'b1, 32'h0);
    settle(); chk_req("mrst_req", 1'b1, 32'h100);
    tick(); chk_id("late", 1'b0, 32'h0, NOP);
    chk("late.state", {30'd0, dbg_state}, 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
